// File: rtl/fpu_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module : fpu_div_sequencer
// Issue/collect stage around a combinational single-precision divider.
// Special operands are resolved locally; normal pairs use a settle window.
// Rev    : 1.0
// ============================================================================
module fpu_div_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_result,
  input  logic        div_nan_error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags,
  output logic [15:0] dbz_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CLASSIFY = 2'd1,
    S_WAIT     = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  localparam logic [3:0]  c_SETTLE_M1 = 4'(SETTLE_CYCLES - 1);
  localparam logic [31:0] c_QNAN      = 32'h7FC0_0000;

  state_t      r_state, w_next;
  logic [31:0] r_a, r_b, r_result, w_result;
  logic [3:0]  r_flags, w_flags, r_cnt, w_cnt;
  logic [15:0] r_dbz_count;
  logic        w_dbz_inc, w_accept;

  // Operand classification; denormals collapse into the zero class.
  logic w_a_max, w_b_max, w_a_zero, w_b_zero;
  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_fin_nz, w_sign;

  assign w_a_max    = &r_a[30:23];
  assign w_b_max    = &r_b[30:23];
  assign w_a_zero   = ~|r_a[30:23];
  assign w_b_zero   = ~|r_b[30:23];
  assign w_a_nan    = w_a_max && (|r_a[22:0]);
  assign w_b_nan    = w_b_max && (|r_b[22:0]);
  assign w_a_inf    = w_a_max && !(|r_a[22:0]);
  assign w_b_inf    = w_b_max && !(|r_b[22:0]);
  assign w_a_fin_nz = !w_a_max && !w_a_zero;
  assign w_sign     = r_a[31] ^ r_b[31];

  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = (r_state == S_HOLD);
  assign out_result = r_result;
  assign out_flags  = r_flags;
  assign div_a      = r_a;
  assign div_b      = r_b;
  assign dbz_count  = r_dbz_count;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_cnt     = r_cnt;
    w_result  = r_result;
    w_flags   = r_flags;
    w_dbz_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_CLASSIFY;
      end
      S_CLASSIFY: begin
        w_next = S_HOLD;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
          w_result = c_QNAN;
          w_flags  = 4'b1000;
        end else if (w_a_fin_nz && w_b_zero) begin
          w_result  = {w_sign, 31'h7F80_0000};
          w_flags   = 4'b0110;
          w_dbz_inc = 1'b1;
        end else if (w_a_inf) begin
          w_result = {w_sign, 31'h7F80_0000};
          w_flags  = 4'b0010;
        end else if (w_b_inf || w_a_zero) begin
          w_result = {w_sign, 31'h0};
          w_flags  = 4'b0001;
        end else begin
          w_cnt  = c_SETTLE_M1;
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = S_HOLD;
          if (div_nan_error) begin
            w_result = c_QNAN;
            w_flags  = 4'b1000;
          end else begin
            w_result = div_result;
            w_flags  = {2'b00, &div_result[30:23], ~|div_result[30:23]};
          end
        end else begin
          w_cnt = r_cnt - 4'd1;
        end
      end
      S_HOLD: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= 32'h0;
      r_b         <= 32'h0;
      r_cnt       <= 4'd0;
      r_result    <= 32'h0;
      r_flags     <= 4'h0;
      r_dbz_count <= 16'h0;
    end else begin
      r_cnt    <= w_cnt;
      r_result <= w_result;
      r_flags  <= w_flags;
      if (w_accept) begin
        r_a <= in_a;
        r_b <= in_b;
      end
      if (w_dbz_inc && (r_dbz_count != 16'hFFFF)) r_dbz_count <= r_dbz_count + 16'd1;
    end
  end

endmodule
`default_nettype wire
